// File: rtl/axi_mini_pkg.sv
// Shared constants and state encoding for the 4-bit AXI-lite-style mini link.
package axi_mini_pkg;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_TIMEOUT = 15;

  // Master FSM encoding, kept as plain constants so older tools and
  // hand-written probes can match the raw state value.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD_A = 3'd1;
  localparam state_t ST_RD_D = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_RESP = 3'd4;

endpackage

// File: rtl/axi_mini_if.sv
// AR/R and AW/W channel bundle between the mini master and the mini slave.
interface axi_mini_if
  import axi_mini_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              m_arvalid;
  logic [ADDR_W-1:0] m_araddr;
  logic              s_arready;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;
  logic              m_rready;
  logic              m_awvalid;
  logic [ADDR_W-1:0] m_awaddr;
  logic              s_awready;
  logic              m_wvalid;
  logic [DATA_W-1:0] m_wdata;
  logic              s_wready;

  modport master (
    output m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr, m_wvalid, m_wdata,
    input  s_arready, s_rvalid, s_rdata, s_awready, s_wready
  );

  modport slave (
    input  m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr, m_wvalid, m_wdata,
    output s_arready, s_rvalid, s_rdata, s_awready, s_wready
  );

endinterface

// File: rtl/axi_mini_wdog.sv
// Wait-state watchdog: counts cycles spent waiting on the slave and flags the
// last permitted cycle. Saturates at TIMEOUT rather than wrapping.
module axi_mini_wdog
  import axi_mini_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Count waiting cycles; clear has priority so a fresh wait state starts at 0.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != CW'(TIMEOUT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of completed waiting cycles, so the current cycle is
  // the TIMEOUT-th one when cnt equals TIMEOUT-1.
  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/axi_mini_master.sv
// Initiator for the mini register link: takes one read/write command, runs it
// over AR/R or AW/W, and returns read data or a timeout error.
module axi_mini_master
  import axi_mini_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  axi_mini_if.master        bus
);

  state_t state;
  logic   aw_done, w_done;
  logic   aw_ok, w_ok;
  logic   wd_clr, wd_en, wd_expired;

  // The only unregistered output: accept commands whenever idle.
  assign cmd_ready = (state == ST_IDLE);

  // A channel counts as finished if it already completed or completes now.
  assign aw_ok = aw_done | bus.s_awready;
  assign w_ok  = w_done  | bus.s_wready;

  // One watchdog serves every wait state; restart it on command accept and
  // on the AR -> R hand-over so each read phase gets its own budget.
  assign wd_clr = (state == ST_IDLE) || (state == ST_RD_A && bus.s_arready);
  assign wd_en  = (state == ST_RD_A) || (state == ST_RD_D) || (state == ST_WR);

  axi_mini_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Transaction FSM with all bus and response outputs registered.
  // NOTE: every output register is in the async reset so the link goes quiet
  // the instant rst_n falls, even mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      bus.m_arvalid <= 1'b0;
      bus.m_araddr  <= '0;
      bus.m_rready  <= 1'b0;
      bus.m_awvalid <= 1'b0;
      bus.m_awaddr  <= '0;
      bus.m_wvalid  <= 1'b0;
      bus.m_wdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              bus.m_awaddr  <= cmd_addr;
              bus.m_wdata   <= cmd_wdata;
              bus.m_awvalid <= 1'b1;
              bus.m_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= ST_WR;
            end else begin
              bus.m_araddr  <= cmd_addr;
              bus.m_arvalid <= 1'b1;
              state         <= ST_RD_A;
            end
          end
        end
        ST_RD_A: begin
          if (bus.s_arready) begin
            bus.m_arvalid <= 1'b0;
            bus.m_rready  <= 1'b1;
            state         <= ST_RD_D;
          end else if (wd_expired) begin
            bus.m_arvalid <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RD_D: begin
          bus.m_rready <= 1'b0;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
          if (bus.s_rvalid) begin
            rsp_rdata <= bus.s_rdata;
            rsp_err   <= 1'b0;
          end else if (wd_expired) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            // Still waiting: undo the speculative exit above.
            bus.m_rready <= 1'b1;
            rsp_valid    <= 1'b0;
            state        <= ST_RD_D;
          end
        end
        ST_WR: begin
          if ((aw_ok && w_ok) || wd_expired) begin
            bus.m_awvalid <= 1'b0;
            bus.m_wvalid  <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= !(aw_ok && w_ok);
            rsp_valid     <= 1'b1;
            state         <= ST_RESP;
          end else begin
            if (bus.s_awready) begin
              aw_done       <= 1'b1;
              bus.m_awvalid <= 1'b0;
            end
            if (bus.s_wready) begin
              w_done       <= 1'b1;
              bus.m_wvalid <= 1'b0;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mini_master.sv
// Bench for axi_mini_master: each directed transaction is turned into an
// expected per-cycle timeline from the slave's ready/valid cycle numbers, and a
// single compare process checks every output against that timeline.
module tb_axi_mini_master;
  import axi_mini_pkg::*;

  localparam int T = 15;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [3:0] rsp_rdata;

  axi_mini_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  axi_mini_master #(.ADDR_W(4), .DATA_W(4), .TIMEOUT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One directed transaction. a/b are the cycles (relative to command accept
  // at cycle 0) in which the slave pulses arready/rvalid (read) or
  // awready/wready (write); 0 means never. hold = cycles rsp_ready stays low
  // after rsp_valid rises. lit_* are hand-computed results.
  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [3:0] wdata;
    int         a;
    int         b;
    logic [3:0] rdata;
    int         hold;
    bit         noise;
    int         rst_at;
    int         lit_rise;
    logic [3:0] lit_rdata;
    bit         lit_err;
  } scn_t;

  // Expected timeline: last waiting cycle, error flag, and valid windows.
  typedef struct {
    int e;
    bit err;
    int arv_last;
    int rr_first;
    int rr_last;
    int awv_last;
    int wv_last;
    int rise;
  } tl_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic       exp_cmd_ready, exp_arvalid, exp_rready, exp_awvalid, exp_wvalid;
  logic       exp_rsp_valid, exp_rsp_err;
  logic [3:0] exp_addr, exp_wdata, exp_rdata;

  int         obs_rise;
  logic [3:0] obs_rdata;
  logic       obs_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @cycle %0d t=%0t: got 0x%0h, want 0x%0h", name, cyc, $time, act, want);
    end
  endtask

  function automatic bit in_win(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Timeline from the handshake rules: a channel completes in the cycle its
  // ready lands within T waiting cycles, otherwise the transaction aborts at T.
  function automatic tl_t plan(input scn_t s);
    tl_t t;
    t = '{default: 0};
    t.rr_first = 1;
    if (!s.wr) begin
      if (s.a >= 1 && s.a <= T) begin
        t.arv_last = s.a;
        t.rr_first = s.a + 1;
        if (s.b > s.a && s.b <= s.a + T) begin
          t.e = s.b; t.err = 1'b0;
        end else begin
          t.e = s.a + T; t.err = 1'b1;
        end
        t.rr_last = t.e;
      end else begin
        t.arv_last = T; t.e = T; t.err = 1'b1; t.rr_last = 0;
      end
    end else begin
      bit aw_ok, w_ok;
      aw_ok = s.a >= 1 && s.a <= T;
      w_ok  = s.b >= 1 && s.b <= T;
      if (aw_ok && w_ok) begin
        t.e = (s.a > s.b) ? s.a : s.b; t.err = 1'b0;
      end else begin
        t.e = T; t.err = 1'b1;
      end
      t.awv_last = aw_ok ? s.a : T;
      t.wv_last  = w_ok  ? s.b : T;
    end
    t.rise = t.e + 1;
    return t;
  endfunction

  function automatic scn_t mk(input bit wr, input int addr, input int wdata, input int a,
                              input int b, input int rdata, input int hold, input bit noise,
                              input int rst_at, input int lit_rise, input int lit_rdata,
                              input bit lit_err);
    scn_t s;
    s.wr = wr; s.addr = 4'(addr); s.wdata = 4'(wdata); s.a = a; s.b = b;
    s.rdata = 4'(rdata); s.hold = hold; s.noise = noise; s.rst_at = rst_at;
    s.lit_rise = lit_rise; s.lit_rdata = 4'(lit_rdata); s.lit_err = lit_err;
    return s;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 4'h0;
    rsp_ready = 1'b0;
    bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = 4'h0;
    bus.s_awready = 1'b0; bus.s_wready = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_arvalid", bus.m_arvalid, 0);
    check("rst_araddr", bus.m_araddr, 0);
    check("rst_rready", bus.m_rready, 0);
    check("rst_awvalid", bus.m_awvalid, 0);
    check("rst_awaddr", bus.m_awaddr, 0);
    check("rst_wvalid", bus.m_wvalid, 0);
    check("rst_wdata", bus.m_wdata, 0);
  endtask

  // Mid-transaction reset: outputs must clear at once, and no response follows.
  task automatic reset_pulse();
    chk_en = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_cmd_ready", cmd_ready, 1);
    end
  endtask

  task automatic run(input scn_t s);
    tl_t t;
    int  last;
    t = plan(s);
    last = t.rise + s.hold;
    obs_rise = -1; obs_rdata = 4'h0; obs_err = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == s.rst_at) begin
        reset_pulse();
        return;
      end
      cyc = c;
      chk_en = 1'b1;
      exp_cmd_ready = (c == 0);
      exp_arvalid   = !s.wr && in_win(c, 1, t.arv_last);
      exp_rready    = !s.wr && in_win(c, t.rr_first, t.rr_last);
      exp_awvalid   = s.wr && in_win(c, 1, t.awv_last);
      exp_wvalid    = s.wr && in_win(c, 1, t.wv_last);
      exp_addr      = s.addr;
      exp_wdata     = s.wdata;
      exp_rsp_valid = (c >= t.rise);
      exp_rsp_err   = t.err;
      exp_rdata     = (t.err || s.wr) ? 4'h0 : s.rdata;
      cmd_valid = (c == 0); cmd_write = s.wr; cmd_addr = s.addr; cmd_wdata = s.wdata;
      rsp_ready = (c >= last);
      if (!s.wr) begin
        bus.s_arready = (s.a > 0 && c == s.a);
        bus.s_rvalid  = (s.b > 0 && c == s.b) || (s.noise && c == 0);
        bus.s_rdata   = (s.b > 0 && c == s.b) ? s.rdata : 4'hE;
        bus.s_awready = s.noise;
        bus.s_wready  = s.noise;
      end else begin
        bus.s_awready = (s.a > 0 && c == s.a);
        bus.s_wready  = (s.b > 0 && c == s.b);
        bus.s_arready = s.noise;
        bus.s_rvalid  = s.noise;
        bus.s_rdata   = 4'hE;
      end
    end
    #2;
    chk_en = 1'b0;
    check("lit_rise", obs_rise, s.lit_rise);
    check("lit_rdata", obs_rdata, s.lit_rdata);
    check("lit_err", obs_err, s.lit_err);
  endtask

  // Compare process: every cycle of a transaction, all outputs vs. timeline.
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      check("cmd_ready", cmd_ready, exp_cmd_ready);
      check("arvalid", bus.m_arvalid, exp_arvalid);
      if (exp_arvalid) check("araddr", bus.m_araddr, exp_addr);
      check("rready", bus.m_rready, exp_rready);
      check("awvalid", bus.m_awvalid, exp_awvalid);
      if (exp_awvalid) check("awaddr", bus.m_awaddr, exp_addr);
      check("wvalid", bus.m_wvalid, exp_wvalid);
      if (exp_wvalid) check("wdata", bus.m_wdata, exp_wdata);
      check("rsp_valid", rsp_valid, exp_rsp_valid);
      if (exp_rsp_valid) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_rsp_err);
      end
      if (rsp_valid && obs_rise < 0) begin
        obs_rise  = cyc;
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
      end
    end
  end

  scn_t list [$];

  initial begin
    //           wr addr wd  a   b   rd  hold noise rst  rise rdata err
    list.push_back(mk(0, 3, 0,  1,  2,  7,  0, 0, -1,  3, 7,    0)); // basic read
    list.push_back(mk(1, 3, 4,  1,  3,  0,  0, 0, -1,  4, 0,    0)); // split write
    list.push_back(mk(0, 9, 0,  0,  0,  0,  0, 0, -1, 16, 0,    1)); // AR timeout
    list.push_back(mk(0, 5, 0,  2,  4, 10,  5, 0, -1,  5, 10,   0)); // rsp backpressure
    list.push_back(mk(1, 12, 9, 1,  1,  0,  0, 1, -1,  2, 0,    0)); // same-cycle write
    list.push_back(mk(0, 1, 0, 15, 16,  3,  0, 1, -1, 17, 3,    0)); // arready on last cycle
    list.push_back(mk(1, 6, 11, 2,  0,  0,  2, 0, -1, 16, 0,    1)); // W timeout
    list.push_back(mk(0, 2, 0,  1, 16,  5,  0, 0, -1, 17, 5,    0)); // rvalid on last cycle
    list.push_back(mk(1, 7, 1,  3, 15,  0,  1, 0, -1, 16, 0,    0)); // wready on last cycle
    list.push_back(mk(0, 8, 0,  2,  2,  6,  0, 0, -1, 18, 0,    1)); // early rvalid ignored
    list.push_back(mk(0, 4, 0,  1,  0,  0,  0, 0,  3,  0, 0,    0)); // reset in RD_D
    list.push_back(mk(0, 3, 0,  1,  2,  7,  0, 0, -1,  3, 7,    0)); // read after reset

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (list[i]) run(list[i]);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
